// File: rtl/snd_pkg.sv
// Shared types and helpers for the sound output conditioner.
// Optional build macro used by the top: SND_SIGMA_DELTA_EN.
package snd_pkg;

  localparam int SND_SAMPLE_W = 16;
  localparam int SND_STATE_W  = 20;
  localparam int SND_ACC_W    = 27;

  typedef logic signed [SND_SAMPLE_W-1:0] sample_t;
  typedef logic signed [SND_STATE_W-1:0]  state_t;

  localparam state_t SAT_HI = 20'sd32767;
  localparam state_t SAT_LO = -20'sd32768;

  // Clamp a 20-bit signed value into the 16-bit PCM range.
  function automatic sample_t sat16(input state_t v);
    sample_t r;
    if (v > SAT_HI) begin
      r = 16'sh7fff;
    end else if (v < SAT_LO) begin
      r = 16'sh8000;
    end else begin
      r = v[SND_SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/snd_sigma_delta.sv
// First-order sigma-delta modulator producing a 1-bit DAC stream from the
// current PCM sample. Only instantiated when SND_SIGMA_DELTA_EN is defined.
module snd_sigma_delta
  import snd_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  sample_t sample,
  output logic    dac_out
);

  logic [15:0] level;
  logic [16:0] err_acc;

  // Offset-binary view of the signed sample: 0 maps to mid-scale.
  assign level = {~sample[15], sample[14:0]};

  // Error accumulator; the carry out of the low 16 bits is the output bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_acc <= '0;
    end else begin
      err_acc <= {1'b0, err_acc[15:0]} + {1'b0, level};
    end
  end

  assign dac_out = err_acc[16];

endmodule

// File: rtl/snd_out_conditioner.sv
// Audio post-stage for the PSG: resample to FS_HZ, DC block, low-pass,
// gain/mute, 16-bit signed PCM with a one-cycle strobe.
// Build macro SND_SIGMA_DELTA_EN adds a 1-bit sigma-delta DAC on dac_out;
// without it dac_out is tied low.
//
// Output handshake: sample_stb is a single-cycle valid pulse with no ready;
// sample_out changes only on the cycle sample_stb is high and holds between
// strobes. Consumers must take the sample on the strobe cycle.
module snd_out_conditioner
  import snd_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int FS_HZ    = 48000,
  parameter int DC_SHIFT = 8,
  parameter int LP_SHIFT = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     sndin,
  input  logic [3:0]                     vol,
  input  logic                           mute,
  output logic signed [SND_SAMPLE_W-1:0] sample_out,
  output logic                           sample_stb,
  output logic                           dac_out
);

  localparam logic [SND_ACC_W-1:0] ACC_INC = SND_ACC_W'(FS_HZ);
  localparam logic [SND_ACC_W-1:0] ACC_MOD = SND_ACC_W'(CLK_HZ);

  // Input synchroniser
  logic [7:0] sync1, sync2;

  // Fractional strobe generator
  logic [SND_ACC_W-1:0] acc, acc_sum;
  logic                 tick;

  // Pipeline valids (S1..S3); S4 valid is sample_stb itself
  logic v1, v2, v3;

  // Filter state
  logic signed [16:0] x, x_prev;
  state_t             y, z;
  logic signed [21:0] dc_sum;
  logic signed [20:0] lp_diff, lp_step, lp_sum;

  // Gain stage
  logic signed [24:0] gain_prod, gain_shr;
  state_t             gain_20;

  // Two-flop sync of the PSG level; bit skew is harmless since it is only
  // consumed at tick, long after it has settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sndin;
      sync2 <= sync1;
    end
  end

  assign acc_sum = acc + ACC_INC;

  // Phase accumulator: one tick each time it wraps past CLK_HZ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum >= ACC_MOD) begin
      acc  <= acc_sum - ACC_MOD;
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum;
      tick <= 1'b0;
    end
  end

  // S1: capture the synchronised level as a signed 17-bit sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      x      <= '0;
      x_prev <= '0;
    end else begin
      v1 <= tick;
      if (tick) begin
        x_prev <= x;
        x      <= {2'b00, sync2, 7'b0000000};
      end
    end
  end

  assign dc_sum = 22'(x) - 22'(x_prev) + 22'(y) - 22'(y >>> DC_SHIFT);

  // S2: DC blocker, y decays by y>>>DC_SHIFT per sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0;
      y  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        y <= dc_sum[SND_STATE_W-1:0];
      end
    end
  end

  // Difference is formed one bit wider so it cannot wrap before the shift.
  assign lp_diff = 21'(y) - 21'(z);
  assign lp_step = lp_diff >>> LP_SHIFT;
  assign lp_sum  = 21'(z) + lp_step;

  // S3: one-pole low-pass (LP_SHIFT=0 makes z follow y exactly).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3 <= 1'b0;
      z  <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        z <= lp_sum[SND_STATE_W-1:0];
      end
    end
  end

  assign gain_prod = 25'(z) * 25'($signed({1'b0, vol}));
  assign gain_shr  = gain_prod >>> 3;

  // Pre-clamp the wide product into the 20-bit state range for sat16.
  always_comb begin
    gain_20 = gain_shr[SND_STATE_W-1:0];
    if (gain_shr > 25'sd524287) begin
      gain_20 = 20'sh7ffff;
    end else if (gain_shr < -25'sd524288) begin
      gain_20 = 20'sh80000;
    end
  end

  // S4: gain, saturate, mute, and publish with a one-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= v3;
      if (v3) begin
        sample_out <= mute ? sample_t'(0) : sat16(gain_20);
      end
    end
  end

`ifdef SND_SIGMA_DELTA_EN
  snd_sigma_delta u_sigma_delta (
    .clk     (clk),
    .reset   (reset),
    .sample  (sample_out),
    .dac_out (dac_out)
  );
`else
  assign dac_out = 1'b0;
`endif

endmodule

// File: doc/snd_out_conditioner.md
Name: snd_out_conditioner

Overview:
Audio post-stage directly downstream of the SN76496 sound generator. Takes the raw 8-bit unsigned PSG level and resamples it to a fixed output rate with a fractional strobe generator. It then removes DC, low-pass smooths the result, applies volume/mute, and emits a 16-bit signed PCM sample with a one-cycle valid strobe for the board audio path.

Parameters:
CLK_HZ, 50000000, system clock frequency (integer Hz)
FS_HZ, 48000, output sample rate; must be < CLK_HZ
DC_SHIFT, 8, DC-blocker pole: y decays by y>>>DC_SHIFT per sample
LP_SHIFT, 2, low-pass coefficient 2^-LP_SHIFT; 0 = bypass

Ports:
clk  in  1  system clock (same domain as dacclk)
reset  in  1  asynchronous, active-high reset
sndin  in  8  raw PSG output, unsigned, other clock domain
vol  in  4  gain; 8 = unity, 0 = silence, 15 = 1.875x
mute  in  1  force output samples to 0
sample_out  out  16  signed PCM sample
sample_stb  out  1  one-cycle pulse, sample_out valid/updated
dac_out  out  1  1-bit sigma-delta output (see Optional Feature)

Behaviour:
- Reset: reset is asynchronous, active-high. It clears all state, the phase accumulator, the sync flops and the pipeline. Outputs after reset: sample_out=0, sample_stb=0, dac_out=0.
- Input sync: sndin passes through 2 flops every clk. Multi-bit skew is tolerated because sampling happens only at tick.
- Strobe generator:
  - 27-bit accumulator; each clk: acc += FS_HZ.
  - If the new value is >= CLK_HZ: subtract CLK_HZ in the same cycle and assert internal tick for 1 cycle.
  - Exactly FS_HZ ticks per CLK_HZ clocks; never 2 ticks in consecutive cycles.
- Pipeline, tick at cycle t:
  - t+1, S1 capture: x = {sync_sndin,7'b0} as signed 17-bit (0..32640). Keep x_prev.
  - t+2, S2 DC blocker: y = x - x_prev + y_prev - (y_prev>>>DC_SHIFT). 20-bit signed state, arithmetic shift.
  - t+3, S3 low-pass: z = z_prev + ((y - z_prev)>>>LP_SHIFT). 20-bit signed state.
  - t+4, S4 gain: p = (z*vol)>>>3, saturated to [-32768, 32767]. If mute, 0. Register into sample_out; assert sample_stb for exactly 1 cycle.
- Latency: tick to sample_stb is 4 clocks. sample_out holds between strobes.
- Filter state (x_prev, y, z) keeps updating while mute=1, so unmute produces no click beyond the current state.
- vol and mute are sampled at S4 only. Changes between ticks take effect on the next sample.
- Reset mid-pipeline: any in-flight sample is discarded and no stb is emitted. The first stb after release occurs on the first tick+4.

Optional Feature:
SND_SIGMA_DELTA_EN:
- Defined: a first-order sigma-delta modulator runs every clk. Input is sample_out offset to unsigned ({~s[15],s[14:0]}). 17-bit error accumulator; dac_out is the accumulator carry.
- Undefined: dac_out tied 0 and no modulator logic is present.

Decomposition:
- Package snd_pkg: SND_SAMPLE_W=16, SND_STATE_W=20, sample typedef, and a sat16 function (20-to-16 signed clamp).
- One sub-module, snd_sigma_delta: instantiated only under SND_SIGMA_DELTA_EN.

Test Plan:
- Strobe rate: defaults, reset released. First sample_stb at clock 1042+4 after release; exactly 960 strobes in 1,000,000 clocks; no consecutive-cycle ticks.
- Step response: vol=8, sndin 0→255 held. First sample after change is 8160 (y=32640, z=8160). Subsequent samples decay toward 0; after 4000 samples |sample_out| < 64.
- Saturation: LP_SHIFT=0, vol=15, step 0→255. First sample is 32767, not 61200 wrapped. Repeat with step 255→0: -32768.
- Mute: during the step test assert mute. sample_out=0 while strobes continue. Deassert mute: the next sample equals the unmuted reference model value, showing state continued.
- Async reset mid-pipeline: assert reset 2 clocks after a tick. Outputs are 0 immediately (before the next clk edge); no stb from the aborted sample; the post-release sequence matches a fresh run.
- SND_SIGMA_DELTA_EN: constant sample_out=0 gives dac_out ones-density 50% ±0.1% over 65536 clocks. Without the macro, dac_out stays 0.
